// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared state encoding and default sizing for the FIFO write
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int c_DEF_NUM_REQ   = 4;
    localparam int c_DEF_DATA_W    = 8;
    localparam int c_DEF_MAX_BURST = 4;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_BURST = 1'b1;

    // Index width that never collapses to zero bits for a count of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first asserted request at
//               or above rr_ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               any,
    output logic [PTR_W-1:0]   idx
);

    localparam int c_CAND_W = PTR_W + 1;
    localparam logic [c_CAND_W-1:0] c_NUM = c_CAND_W'(NUM_REQ);

    logic [c_CAND_W-1:0] w_cand;
    logic                w_found;
    logic [PTR_W-1:0]    w_idx;

    // rr_ptr is always below NUM_REQ, so one conditional subtract wraps it.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, rr_ptr} + c_CAND_W'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            if (!w_found && req[w_cand[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    assign any = w_found;
    assign idx = w_idx;

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-bounded arbiter sharing one FIFO write
//               port among NUM_REQ valid/ack producers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = c_DEF_NUM_REQ,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int MAX_BURST = c_DEF_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      fifo_full
);

    localparam int c_PTR_W = idx_width(NUM_REQ);
    localparam int c_CNT_W = idx_width(MAX_BURST);
    localparam logic [c_PTR_W-1:0] c_LAST_REQ  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_beat_cnt;

    logic                 w_any;
    logic [c_PTR_W-1:0]   w_pick;
    logic [DATA_W-1:0]    w_lane [NUM_REQ];
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [DATA_W-1:0]    w_owner_data;
    logic                 w_in_burst;
    logic                 w_owner_req;
    logic                 w_write;
    logic                 w_last_beat;
    logic                 w_burst_end;
    logic [c_PTR_W-1:0]   w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .idx    (w_pick)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_owner_oh   = '0;
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == c_PTR_W'(i)) begin
                w_owner_oh[i] = 1'b1;
                w_owner_data  = w_lane[i];
            end
        end
    end

    // A dropped request ends the burst even while the FIFO is full.
    assign w_in_burst  = (r_state == c_ST_BURST);
    assign w_owner_req = |(req & w_owner_oh);
    assign w_write     = w_in_burst & w_owner_req & ~fifo_full;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    assign w_burst_end = w_in_burst & (~w_owner_req | (w_write & w_last_beat));
    assign w_next_ptr  = (r_owner == c_LAST_REQ) ? '0 : r_owner + 1'b1;

    assign gnt          = w_in_burst ? w_owner_oh : '0;
    assign ack          = w_write ? w_owner_oh : '0;
    assign fifo_wr_en   = w_write;
    assign fifo_data_in = w_write ? w_owner_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_BURST;
                    end
                end
                default: begin
                    if (w_write) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_burst_end) begin
                        r_state  <= c_ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            endcase
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter with a cycle-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    gnt;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic            fifo_full = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] prod_q [N][$];
    logic [N-1:0]  pop = '0;
    logic [DW-1:0] wr_log [$];
    int            wr_cyc [$];
    int            gnt_log [$];
    logic [N-1:0]  prev_gnt = '0;
    bit            chk_en = 1'b0;

    // Reference model: who holds the port, beats granted so far, next priority.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (prod_q[i].size() > 0);
            req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        end
        drive();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) prod_q[i].delete();
        fifo_full = 1'b0;
        drive();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wr_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, wr_log.size(), n);
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] exp [$]);
        check({name, "_count"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < wr_log.size()) check($sformatf("%s[%0d]", name, i), wr_log[i], exp[i]);
        end
    endtask

    task automatic check_grants(input string name, input int exp [$]);
        check({name, "_count"}, gnt_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < gnt_log.size()) check($sformatf("%s[%0d]", name, i), gnt_log[i], exp[i]);
        end
    endtask

    // Per-cycle comparison against the model, then model advance for the edge.
    always @(negedge clk) begin : cmp
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_ack;
        logic          e_wr;
        logic [DW-1:0] e_data;
        bit            found;
        int            j;
        if (chk_en) begin
            e_gnt  = '0;
            e_ack  = '0;
            e_wr   = 1'b0;
            e_data = '0;
            if (m_busy) begin
                e_gnt[m_owner] = 1'b1;
                if (req[m_owner] && !fifo_full) begin
                    e_wr           = 1'b1;
                    e_ack[m_owner] = 1'b1;
                    e_data         = req_data[m_owner*DW +: DW];
                end
            end
            check("gnt", gnt, e_gnt);
            check("ack", ack, e_ack);
            check("fifo_wr_en", fifo_wr_en, e_wr);
            check("fifo_data_in", fifo_data_in, e_data);

            if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(oh_index(gnt));
            prev_gnt = gnt;
            if (fifo_wr_en) begin
                wr_log.push_back(fifo_data_in);
                wr_cyc.push_back(cyc);
            end
            pop = ack;

            if (rst) begin
                m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
            end else if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && req[j]) begin
                        found = 1'b1; m_busy = 1'b1; m_owner = j; m_beats = 0;
                    end
                end
            end else begin
                if (e_wr) m_beats++;
                if (!req[m_owner] || (e_wr && m_beats == MB)) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end else begin
            pop = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        // Reset values
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_ack", ack, 4'b0000);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_data", fifo_data_in, 8'h00);
        step();
        rst = 1'b0;

        // Idle: no requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt", gnt, 4'b0000);
            check("idle_wr_en", fifo_wr_en, 1'b0);
            step();
        end

        // Single producer, two bursts of 4 separated by one bubble
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) prod_q[0].push_back(DW'(8'h10 + i));
        drive();
        t0 = cyc;
        wait_writes(8, 40, "single_timeout");
        check_data("single_data", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
        check_grants("single_gnt", '{0, 0});
        if (wr_cyc.size() >= 8) begin
            check("single_latency", wr_cyc[0] - t0, 1);
            check("single_burst0", wr_cyc[3] - wr_cyc[0], 3);
            check("single_bubble", wr_cyc[4] - wr_cyc[3], 2);
            check("single_burst1", wr_cyc[7] - wr_cyc[4], 3);
        end

        // Round robin between producers 0 and 2
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            prod_q[0].push_back(DW'(8'h20 + i));
            prod_q[2].push_back(DW'(8'h40 + i));
        end
        drive();
        wait_writes(16, 60, "rr_timeout");
        check_data("rr_data", '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h41, 8'h42, 8'h43,
                               8'h24, 8'h25, 8'h26, 8'h27, 8'h44, 8'h45, 8'h46, 8'h47});
        check_grants("rr_gnt", '{0, 2, 0, 2});
        if (wr_cyc.size() >= 16) check("rr_span", wr_cyc[15] - wr_cyc[0], 18);

        // Full stall mid-burst of producer 1; producer 3 must wait
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) prod_q[1].push_back(DW'(8'h30 + i));
        drive();
        wait_writes(1, 10, "stall_first_timeout");
        fifo_full = 1'b1;
        prod_q[3].push_back(8'h60);
        drive();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wr_en", fifo_wr_en, 1'b0);
            check("stall_ack", ack, 4'b0000);
            check("stall_gnt", gnt, 4'b0010);
            step();
        end
        fifo_full = 1'b0;
        wait_writes(5, 30, "stall_timeout");
        check_data("stall_data", '{8'h30, 8'h31, 8'h32, 8'h33, 8'h60});
        check_grants("stall_gnt_seq", '{1, 3});

        // Early drop by producer 3 after two beats
        do_reset();
        clear_logs();
        prod_q[3].push_back(8'h70);
        prod_q[3].push_back(8'h71);
        drive();
        wait_writes(2, 10, "drop_timeout");
        prod_q[0].push_back(8'h80);
        prod_q[1].push_back(8'h90);
        drive();
        @(negedge clk);
        check("drop_gnt", gnt, 4'b1000);
        check("drop_ack", ack, 4'b0000);
        step();
        @(negedge clk);
        check("drop_bubble_gnt", gnt, 4'b0000);
        step();
        @(negedge clk);
        check("drop_next_gnt", gnt, 4'b0001);
        wait_writes(4, 20, "drop_tail_timeout");
        check_data("drop_data", '{8'h70, 8'h71, 8'h80, 8'h90});
        check_grants("drop_gnt_seq", '{3, 0, 1});

        // Reset mid-burst under stall; rr_ptr is 2 beforehand
        clear_logs();
        for (int i = 0; i < 4; i++) prod_q[2].push_back(DW'(8'hA0 + i));
        drive();
        wait_writes(1, 10, "rstb_first_timeout");
        fifo_full = 1'b1;
        prod_q[0].push_back(8'hB0);
        drive();
        @(negedge clk);
        check("rstb_stall_wr_en", fifo_wr_en, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstb_rst_wr_en", fifo_wr_en, 1'b0);
        check("rstb_rst_gnt", gnt, 4'b0100);
        step();
        rst = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        check("rstb_after_gnt", gnt, 4'b0000);
        check("rstb_after_ack", ack, 4'b0000);
        check("rstb_after_wr_en", fifo_wr_en, 1'b0);
        step();
        @(negedge clk);
        check("rstb_first_gnt", gnt, 4'b0001);
        wait_writes(5, 30, "rstb_timeout");
        check_data("rstb_data", '{8'hA0, 8'hB0, 8'hA1, 8'hA2, 8'hA3});
        check_grants("rstb_gnt_seq", '{2, 0, 2});

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
